// File: rtl/hsi_mon_pkg.sv
// hsi_mon_pkg: framer states and default byte constants shared across the HSI monitor path
package hsi_mon_pkg;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_HDR, S_PAY, S_CHK} state_t;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'h4D;
    localparam logic [7:0] IDLE_BYTE_DEF = 8'h5E;
    localparam logic [7:0] MSTR_ADDR_DEF = 8'h0B;
    localparam logic [7:0] SLV_ADDR_DEF  = 8'h09;
    localparam int         HDR_LEN       = 4;
endpackage

// File: rtl/hsi_skid_buf2.sv
// hsi_skid_buf2: two-entry byte buffer, filled one cycle after each read request
module hsi_skid_buf2 (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic [1:0] cnt
);
    logic [7:0] b0, b1;
    logic       pop;
    assign out_valid = cnt != 2'd0;
    assign out_data  = b0;
    assign pop       = out_valid && out_ready;
    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            cnt <= '0;
            b0  <= '0;
            b1  <= '0;
        end else begin
            cnt <= cnt + 2'(in_valid) - 2'(pop);
            b0  <= pop ? (cnt == 2'd1 ? in_data : b1) : (cnt == 2'd0 ? in_data : b0);
            b1  <= in_valid ? in_data : b1;
        end
endmodule

// File: rtl/hsi_monitor_framer.sv
// hsi_monitor_framer: drains the monitor FIFO into SYNC/ADDR/LEN/payload/XOR byte frames
module hsi_monitor_framer
    import hsi_mon_pkg::*;
#(
    parameter int         USEDW_W     = 11,
    parameter int         MAX_PAYLOAD = 1024,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF,
    parameter logic [7:0] MSTR_ADDR   = MSTR_ADDR_DEF,
    parameter logic [7:0] SLV_ADDR    = SLV_ADDR_DEF,
    parameter bit         CHK_EN      = 1'b1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               rd_rdy,
    input  logic               src,
    input  logic [USEDW_W-1:0] usedw,
    output logic               rdreq,
    input  logic [7:0]         d,
    output logic               tx_rdy,
    input  logic               tx_ack,
    output logic [7:0]         q,
    output logic               q_valid,
    input  logic               q_ready,
    output logic               last_byte,
    output logic               busy
);
    localparam logic [USEDW_W-1:0] MAX_LEN = USEDW_W'(MAX_PAYLOAD);
    state_t             state, nxt;
    logic [USEDW_W-1:0] len, rd_cnt, sent;
    logic [15:0]        len16;
    logic [7:0]         chk, hdr_byte, b_data;
    logic [1:0]         hdr_cnt, b_cnt;
    logic               src_l, pending, inflight, b_valid, start, acc, pay_last, finish;

    hsi_skid_buf2 u_buf (
        .clk(clk),
        .n_rst(n_rst),
        .in_valid(inflight),
        .in_data(d),
        .out_valid(b_valid),
        .out_data(b_data),
        .out_ready(q_ready && state == S_PAY),
        .cnt(b_cnt)
    );

    assign len16 = 16'(len);

    always_comb begin
        start     = (rd_rdy || pending) && usedw != '0;
        hdr_byte  = hdr_cnt == 2'd0 ? SYNC_BYTE : hdr_cnt == 2'd1 ? (src_l ? SLV_ADDR : MSTR_ADDR) :
                    hdr_cnt == 2'd2 ? len16[15:8] : len16[7:0];
        q_valid   = state == S_HDR || state == S_CHK || (state == S_PAY && b_valid);
        q         = !q_valid ? IDLE_BYTE : state == S_HDR ? hdr_byte : state == S_PAY ? b_data : chk;
        acc       = q_valid && q_ready;
        pay_last  = sent == len - USEDW_W'(1);
        last_byte = state == S_CHK || (state == S_PAY && b_valid && !CHK_EN && pay_last);
        // the skid buffer must always have room for every read still in flight
        rdreq     = state == S_PAY && 3'(b_cnt) + 3'(inflight) < 3'd2 && rd_cnt < len && usedw != '0;
        finish    = acc && (state == S_CHK || (state == S_PAY && pay_last && !CHK_EN));
        busy      = state != S_IDLE;
        nxt       = state;
        case (state)
            S_IDLE:  nxt = start ? S_REQ : S_IDLE;
            S_REQ:   nxt = tx_ack ? S_HDR : S_REQ;
            S_HDR:   if (acc && hdr_cnt == 2'(HDR_LEN - 1)) nxt = len == '0 ? S_CHK : S_PAY;
            S_PAY:   if (acc && pay_last) nxt = CHK_EN ? S_CHK : S_IDLE;
            S_CHK:   if (acc) nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst)
        if (!n_rst) begin
            state    <= S_IDLE;
            tx_rdy   <= 1'b0;
            len      <= '0;
            src_l    <= 1'b0;
            pending  <= 1'b0;
            hdr_cnt  <= '0;
            rd_cnt   <= '0;
            sent     <= '0;
            chk      <= '0;
            inflight <= 1'b0;
        end else begin
            state <= nxt;
            tx_rdy <= nxt == S_REQ;
            if (state == S_IDLE && start) begin
                len   <= usedw > MAX_LEN ? MAX_LEN : usedw;
                src_l <= src;
            end
            // leftover FIFO data re-arms the next chunk without a new rd_rdy
            pending  <= state == S_IDLE ? pending && !start : pending || rd_rdy || (finish && usedw != '0);
            hdr_cnt  <= state == S_HDR ? hdr_cnt + 2'(acc) : '0;
            rd_cnt   <= state == S_PAY ? rd_cnt + USEDW_W'(rdreq) : '0;
            sent     <= state == S_PAY ? sent + USEDW_W'(acc) : '0;
            chk      <= state == S_IDLE ? '0 : acc && state != S_CHK ? chk ^ q : chk;
            inflight <= rdreq;
        end
endmodule

// File: doc/hsi_monitor_framer.md
Name: hsi_monitor_framer

Overview:
- Parametrised monitor frame builder. Drains a monitor FIFO into byte frames on the HSI transmit path.
- Frame format: SYNC, ADDR, LEN_H, LEN_L, payload, then an optional XOR checksum.
- Adds the following:
  - output backpressure (valid/ready);
  - payload chunking to MAX_PAYLOAD with automatic re-arm while data remains;
  - parametrised length width;
  - checksum trailer.

Parameters:
- USEDW_W, 11, width of FIFO usedw and of the length field. Must be ≤ 16.
- MAX_PAYLOAD, 1024, maximum payload bytes per frame. Range 1..2^USEDW_W-1.
- SYNC_BYTE, 8'h4D, first byte of every frame.
- IDLE_BYTE, 8'h5E, value driven on q while no frame is active.
- MSTR_ADDR, 8'h0B, ADDR byte when src = 0.
- SLV_ADDR, 8'h09, ADDR byte when src = 1.
- CHK_EN, 1, 1 appends the XOR checksum byte.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- rd_rdy  in  1  pulse: FIFO holds a completed capture
- src  in  1  capture source (0 master, 1 slave); sampled with rd_rdy
- usedw  in  USEDW_W  FIFO fill level
- rdreq  out  1  FIFO read request; data arrives on d one clock later
- d  in  8  FIFO read data
- tx_rdy  out  1  frame pending, request to transmitter
- tx_ack  in  1  transmitter grants the frame start
- q  out  8  output byte
- q_valid  out  1  q carries a frame byte
- q_ready  in  1  downstream accepts q this cycle
- last_byte  out  1  high with the final byte of a frame
- busy  out  1  state ≠ IDLE

Behaviour:
- Reset (asynchronous, active-low on n_rst; all flops):
  - tx_rdy = 0, rdreq = 0, q = IDLE_BYTE, q_valid = 0, last_byte = 0, busy = 0.
  - Counters, checksum and pending flag cleared.
- States: IDLE, REQ, HDR, PAY, CHK.
- IDLE:
  - Entered on a rd_rdy pulse, or with the pending flag set, when usedw ≠ 0.
  - On entry, latch len = min(usedw, MAX_PAYLOAD) and src_l = src. Go to REQ.
  - rd_rdy with usedw = 0 is ignored.
- REQ:
  - tx_rdy = 1 from the cycle after entry.
  - tx_ack clears tx_rdy on the next edge and moves to HDR.
  - tx_ack in any other state is ignored.
- HDR:
  - Four bytes, each held on q with q_valid = 1 until q_ready.
  - Bytes in order: SYNC_BYTE; ADDR (from src_l); LEN_H = len[15:8], zero-extended; LEN_L = len[7:0].
  - Then go to PAY, or to CHK if len = 0 (cannot occur; kept for robustness).
- PAY:
  - Emits len bytes from d through a 2-entry skid buffer.
  - rdreq is asserted in a cycle only if all three hold:
    - (buffer occupancy + reads in flight) < 2;
    - reads issued < len;
    - usedw ≠ 0.
  - If usedw reaches 0 early, rdreq drops and the block stalls (q_valid = 0) until data arrives. No underflow read is ever issued.
  - After the last payload byte is accepted, go to CHK if CHK_EN, otherwise finish.
- CHK: emits chk = XOR of every byte of the frame already sent (header + payload).
- last_byte:
  - High together with q_valid on the final byte (CHK byte, or the last payload byte when CHK_EN = 0).
  - Stays high until that byte is accepted.
- Finish:
  - Return to IDLE.
  - If usedw ≠ 0 after the frame, set pending, so the next frame starts without a new rd_rdy. This chunks long captures.
- rd_rdy during REQ/HDR/PAY/CHK sets the pending flag; it never alters the current frame.
- q = IDLE_BYTE whenever q_valid = 0 outside a frame.
- Byte counters are USEDW_W bits wide and count up to len with no wrap. The checksum is 8 bits.
- Simultaneous events:
  - q_ready on the final byte together with rd_rdy: frame ends, pending is set, and the next REQ follows immediately.
  - tx_ack in the same cycle tx_rdy rises: accepted.
- Reset mid-frame: abandons the frame immediately. FIFO contents are not flushed.

Decomposition:
- Package hsi_mon_pkg:
  - state enum;
  - default SYNC/IDLE/ADDR constants (shared with the existing monitor reader);
  - header length constant (4).
- Sub-module hsi_skid_buf2: 2-entry byte buffer with valid/ready and a 1-cycle-latency fill input.

Test Plan:
- usedw = 5, src = 0, rd_rdy pulse, tx_ack after 3 cycles, q_ready held 1 -> tx_rdy rises, then bytes 4D 0B 00 05 d0..d4 CHK (XOR of all). last_byte on CHK only. Exactly 5 rdreq cycles.
- MAX_PAYLOAD = 4, usedw = 10, src = 1 -> three frames without further rd_rdy: 4D 09 00 04 ..., 4D 09 00 04 ..., 4D 09 00 02 .... Pending re-arms each time.
- q_ready toggled at random during PAY, for 300 bytes -> no byte dropped or duplicated; q stable while q_valid & !q_ready; at most 2 reads outstanding.
- usedw drops to 0 mid-payload for 6 cycles -> rdreq low, q_valid low, no extra reads; frame resumes and completes with correct CHK.
- CHK_EN = 0, usedw = 1 -> 4D 0B 00 01 d0, with last_byte on d0.
- n_rst asserted during PAY -> all outputs return to reset values asynchronously; next rd_rdy with usedw = 3 produces a clean frame.
